// File: rtl/sli_pkg.sv
// Shared types and widths for the SLI frame sequencer and its trigger timer.
package sli_pkg;

    localparam int FRQ_W        = 2;
    localparam int FRA_W        = 3;
    localparam int EXP_W        = 20;
    localparam int EXPO_CYC_DEF = 524288;

    typedef enum logic [2:0] {
        IDLE,
        SHOW,
        ARM,
        EXPOSE,
        WAIT_RDY,
        ADVANCE
    } state_e;

endpackage

// File: rtl/sli_trig_timer.sv
// Fixed-width pulse generator: trig_o stays high for exactly EXPO_CYC cycles after start_i.
module sli_trig_timer
    import sli_pkg::*;
#(
    parameter int EXPO_CYC = EXPO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    output logic trig_o,
    output logic done_o
);

    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             trig_q, trig_d;

    assign done_o = trig_q && (cnt_q == EXP_W'(EXPO_CYC));
    assign trig_o = trig_q;

    always_comb begin
        cnt_d  = cnt_q;
        trig_d = trig_q;
        if (abort_i) begin
            trig_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            // Counting from 1 makes the compare value equal the high time.
            trig_d = 1'b1;
            cnt_d  = EXP_W'(1);
        end else if (trig_q) begin
            if (done_o) begin
                trig_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
        end
    end

endmodule

// File: rtl/sli_frame_sequencer.sv
// Steps the SLI pattern indices on frame boundaries and fires the camera trigger
// once the new pattern has settled; advances only after the camera acknowledges.
module sli_frame_sequencer
    import sli_pkg::*;
#(
    parameter int NUM_FRA    = 8,
    parameter int NUM_FRQ    = 4,
    parameter int EXPO_CYC   = EXPO_CYC_DEF,
    parameter int SETTLE_FRM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vsync,
    input  logic             mode,
    input  logic             ori_sel,
    input  logic             lut_rdy,
    input  logic             rdy,
    output logic [FRQ_W-1:0] frq,
    output logic [FRA_W-1:0] fra,
    output logic             ori,
    output logic             trig,
    output logic             f_frm,
    output logic             seq_done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             vs_q, rdy_q;
    logic [3:0]       frm_q, frm_d;
    logic [FRQ_W-1:0] frq_q, frq_d;
    logic [FRA_W-1:0] fra_q, fra_d;
    logic             ori_q, ori_d;
    logic             pend_q, pend_d;
    logic             sd_q, sd_d;
    logic             ffrm_q;
    logic             vs_rise, rdy_rise;
    logic             t_start, t_abort, t_done;

    assign vs_rise  = in_vsync & ~vs_q;
    assign rdy_rise = rdy & ~rdy_q;

    sli_trig_timer #(.EXPO_CYC(EXPO_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (t_start),
        .abort_i (t_abort),
        .trig_o  (trig),
        .done_o  (t_done)
    );

    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        frq_d   = frq_q;
        fra_d   = fra_q;
        ori_d   = ori_q;
        pend_d  = pend_q;
        sd_d    = 1'b0;
        t_start = 1'b0;
        t_abort = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (vs_rise) ori_d = ori_sel;
                if (vs_rise && lut_rdy) begin
                    state_d = SHOW;
                    frm_d   = '0;
                end
            end
            SHOW: begin
                if (frm_q == 4'(SETTLE_FRM)) state_d = ARM;
                else if (vs_rise)            frm_d   = frm_q + 1'b1;
            end
            ARM: begin
                if (vs_rise) begin
                    t_start = 1'b1;
                    state_d = EXPOSE;
                end
            end
            EXPOSE: begin
                // An early acknowledge is remembered rather than dropped.
                if (rdy_rise) pend_d  = 1'b1;
                if (t_done)   state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (rdy_rise || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (vs_rise) begin
                    state_d = SHOW;
                    frm_d   = '0;
                    if (fra_q == FRA_W'(NUM_FRA - 1)) begin
                        fra_d = '0;
                        if (frq_q == FRQ_W'(NUM_FRQ - 1)) begin
                            frq_d = '0;
                            sd_d  = 1'b1;
                        end else begin
                            frq_d = frq_q + 1'b1;
                        end
                    end else begin
                        fra_d = fra_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Orientation change restarts the sequence and wins over an advance.
        if (state_q != IDLE && vs_rise && ori_sel != ori_q) begin
            ori_d   = ori_sel;
            frq_d   = '0;
            fra_d   = '0;
            pend_d  = 1'b0;
            sd_d    = 1'b0;
            t_start = 1'b0;
            t_abort = 1'b1;
            state_d = SHOW;
            frm_d   = '0;
        end

        if (mode) begin
            state_d = IDLE;
            frq_d   = '0;
            fra_d   = '0;
            pend_d  = 1'b0;
            sd_d    = 1'b0;
            t_start = 1'b0;
            t_abort = 1'b1;
            frm_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            rdy_q   <= 1'b0;
            frm_q   <= '0;
            frq_q   <= '0;
            fra_q   <= '0;
            ori_q   <= 1'b0;
            pend_q  <= 1'b0;
            sd_q    <= 1'b0;
            ffrm_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            vs_q    <= in_vsync;
            rdy_q   <= rdy;
            frm_q   <= frm_d;
            frq_q   <= frq_d;
            fra_q   <= fra_d;
            ori_q   <= ori_d;
            pend_q  <= pend_d;
            sd_q    <= sd_d;
            ffrm_q  <= (frq_d == '0) && (fra_d == '0);
        end
    end

    assign frq      = frq_q;
    assign fra      = fra_q;
    assign ori      = ori_q;
    assign f_frm    = ffrm_q;
    assign seq_done = sd_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sli_frame_sequencer.sv
// Frame-level bench: drives vsync frames and camera acks, tracks the expected pattern index.
module tb_sli_frame_sequencer;

    localparam int NUM_FRA = 8;
    localparam int NUM_FRQ = 4;
    localparam int EXPO    = 16;
    localparam int SETTLE  = 1;
    localparam int FL      = 40;
    localparam int NPAT    = NUM_FRA * NUM_FRQ;

    logic       clk, rst, in_vsync, mode, ori_sel, lut_rdy, rdy;
    logic [1:0] frq;
    logic [2:0] fra;
    logic       ori, trig, f_frm, seq_done, busy;

    sli_frame_sequencer #(
        .NUM_FRA(NUM_FRA), .NUM_FRQ(NUM_FRQ), .EXPO_CYC(EXPO), .SETTLE_FRM(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .in_vsync(in_vsync), .mode(mode), .ori_sel(ori_sel),
        .lut_rdy(lut_rdy), .rdy(rdy), .frq(frq), .fra(fra), .ori(ori), .trig(trig),
        .f_frm(f_frm), .seq_done(seq_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_idx = 0;

    int         s_trig_hi, s_trig_first, s_sd, s_chg;
    logic [1:0] s_frq0;
    logic [2:0] s_fra0;
    logic       s_ffrm0, s_ori0;

    // One frame of len cycles: vsync high for 4 cycles, optional 3-cycle rdy pulse at cycle ra.
    task automatic frame(input int len, input int ra);
        s_trig_hi = 0; s_trig_first = -1; s_sd = 0; s_chg = 0;
        for (int k = 0; k < len; k++) begin
            in_vsync = (k < 4);
            rdy      = (ra >= 0) && (k >= ra) && (k < ra + 3);
            @(posedge clk); #1;
            if (k == 0) begin
                s_frq0 = frq; s_fra0 = fra; s_ffrm0 = f_frm; s_ori0 = ori;
            end else if (frq !== s_frq0 || fra !== s_fra0) begin
                s_chg++;
            end
            if (trig === 1'b1) begin
                s_trig_hi++;
                if (s_trig_first < 0) s_trig_first = k;
            end
            if (seq_done === 1'b1) s_sd++;
        end
        in_vsync = 1'b0;
        rdy      = 1'b0;
    endtask

    // Settle frame, exposure frame with ack at cycle ra, then the frame showing the next pattern.
    task automatic capture(input int ra);
        int  old_idx;
        bit  wrap;
        old_idx = exp_idx;
        frame(FL, -1);
        n_chk++; if (s_trig_hi !== 0) $display("FAIL settle_trig: high %0d cycles want 0", s_trig_hi); else n_pass++;
        frame(FL, ra);
        n_chk++; if (s_trig_first !== 0) $display("FAIL trig_start: first high at %0d want 0", s_trig_first); else n_pass++;
        n_chk++; if (s_trig_hi !== EXPO) $display("FAIL trig_width: %0d want %0d", s_trig_hi, EXPO); else n_pass++;
        n_chk++; if (s_chg !== 0 || s_frq0 !== 2'(old_idx / NUM_FRA) || s_fra0 !== 3'(old_idx % NUM_FRA))
            $display("FAIL hold_idx: frq/fra %0d/%0d changes %0d want %0d/%0d", s_frq0, s_fra0, s_chg, old_idx / NUM_FRA, old_idx % NUM_FRA);
        else n_pass++;
        exp_idx = (exp_idx + 1) % NPAT;
        wrap    = (exp_idx == 0);
        frame(FL, -1);
        n_chk++; if (s_frq0 !== 2'(exp_idx / NUM_FRA)) $display("FAIL adv_frq: %0d want %0d", s_frq0, exp_idx / NUM_FRA); else n_pass++;
        n_chk++; if (s_fra0 !== 3'(exp_idx % NUM_FRA)) $display("FAIL adv_fra: %0d want %0d", s_fra0, exp_idx % NUM_FRA); else n_pass++;
        n_chk++; if (s_ffrm0 !== (exp_idx == 0)) $display("FAIL f_frm: %0d want %0d", s_ffrm0, exp_idx == 0); else n_pass++;
        n_chk++; if (s_sd !== (wrap ? 1 : 0)) $display("FAIL seq_done: %0d pulses want %0d", s_sd, wrap ? 1 : 0); else n_pass++;
        n_chk++; if (s_chg !== 0) $display("FAIL midframe_idx: %0d changes want 0", s_chg); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vsync = 1'b0; mode = 1'b0; ori_sel = 1'b0; lut_rdy = 1'b0; rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({trig, seq_done, busy, ori} !== 4'b0) $display("FAIL reset_ctl: trig/sd/busy/ori %b want 0000", {trig, seq_done, busy, ori}); else n_pass++;
        n_chk++; if ({frq, fra} !== 5'd0) $display("FAIL reset_idx: %0d/%0d want 0/0", frq, fra); else n_pass++;
        n_chk++; if (f_frm !== 1'b1) $display("FAIL reset_ffrm: %0d want 1", f_frm); else n_pass++;
        rst = 1'b0;
        frame(FL, -1);
        n_chk++; if (busy !== 1'b0 || s_trig_hi !== 0) $display("FAIL lut_gate: busy %0d trig %0d want 0 0", busy, s_trig_hi); else n_pass++;
    endtask

    task automatic test_first_capture();
        lut_rdy = 1'b1;
        exp_idx = 0;
        frame(FL, -1);
        n_chk++; if (busy !== 1'b1) $display("FAIL start_busy: %0d want 1", busy); else n_pass++;
        n_chk++; if (s_trig_hi !== 0 || s_frq0 !== 2'd0 || s_fra0 !== 3'd0 || s_ffrm0 !== 1'b1)
            $display("FAIL start_state: trig %0d idx %0d/%0d f_frm %0d want 0 0/0 1", s_trig_hi, s_frq0, s_fra0, s_ffrm0);
        else n_pass++;
        capture($urandom_range(20, 30));
    endtask

    task automatic test_sequence();
        repeat (NPAT - 1) capture($urandom_range(1, 30));
    endtask

    task automatic test_rdy_pend();
        capture(5);
    endtask

    task automatic test_ori_change();
        repeat (20) capture($urandom_range(1, 30));
        frame(FL, -1);
        frame(FL, 20);
        ori_sel = 1'b1;
        frame(FL, -1);
        n_chk++; if (s_ori0 !== 1'b1) $display("FAIL ori_flip: %0d want 1", s_ori0); else n_pass++;
        n_chk++; if ({s_frq0, s_fra0} !== 5'd0 || s_sd !== 0)
            $display("FAIL ori_suppress: idx %0d/%0d sd %0d want 0/0 0", s_frq0, s_fra0, s_sd);
        else n_pass++;
        exp_idx = 0;
        frame(FL, -1);
        frame(8, -1);
        n_chk++; if (trig !== 1'b1) $display("FAIL ori_pre_trig: %0d want 1", trig); else n_pass++;
        ori_sel = 1'b0;
        frame(FL, -1);
        n_chk++; if (s_trig_first !== -1 || s_ori0 !== 1'b0) $display("FAIL ori_abort: trig first %0d ori %0d want -1 0", s_trig_first, s_ori0); else n_pass++;
        n_chk++; if ({s_frq0, s_fra0} !== 5'd0) $display("FAIL ori_idx: %0d/%0d want 0/0", s_frq0, s_fra0); else n_pass++;
    endtask

    task automatic test_mode();
        capture($urandom_range(1, 30));
        frame(FL, -1);
        frame(6, -1);
        n_chk++; if (trig !== 1'b1) $display("FAIL mode_pre_trig: %0d want 1", trig); else n_pass++;
        mode = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (trig !== 1'b0 || busy !== 1'b0) $display("FAIL mode_idle: trig %0d busy %0d want 0 0", trig, busy); else n_pass++;
        n_chk++; if ({frq, fra} !== 5'd0 || f_frm !== 1'b1) $display("FAIL mode_idx: %0d/%0d f_frm %0d want 0/0 1", frq, fra, f_frm); else n_pass++;
        mode = 1'b0;
        exp_idx = 0;
    endtask

    task automatic test_reset_mid();
        frame(FL, -1);
        capture($urandom_range(1, 30));
        frame(FL, -1);
        frame(6, -1);
        n_chk++; if (trig !== 1'b1 || fra !== 3'd1) $display("FAIL rst_pre: trig %0d fra %0d want 1 1", trig, fra); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (trig !== 1'b0) $display("FAIL rst_async_trig: %0d want 0", trig); else n_pass++;
        n_chk++; if ({busy, seq_done, ori} !== 3'b0 || {frq, fra} !== 5'd0 || f_frm !== 1'b1)
            $display("FAIL rst_outputs: busy/sd/ori %b idx %0d/%0d f_frm %0d", {busy, seq_done, ori}, frq, fra, f_frm);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_sequence();
        test_rdy_pend();
        test_ori_change();
        test_mode();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
